alu_example_unit: RTL and testbench
===================================

# alu_example_unit

4-bit two-operand ALU with a registered result. It takes operands A and B as individual scalar bit ports and a 2-bit operation select (CTRL). It produces a 4-bit result C, one bit per port. It is a small self-contained datapath leaf used as a timing/interconnect test vehicle, with pin-level scalar ports so each bit can be back-annotated individually.

## Interface
Parameters:
- None. Operand width is fixed at 4 bits and select width at 2 bits.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- vccd1  inout  1  1.8 V supply; present only when USE_POWER_PINS is defined.
- vssd1  inout  1  digital ground; present only when USE_POWER_PINS is defined.
- A0..A3  input  1 each  operand A, bit 0 = LSB.
- B0..B3  input  1 each  operand B, bit 0 = LSB.
- CTRL0, CTRL1  input  1 each  operation select, CTRL0 = LSB.
- C0..C3  output  1 each  registered result, bit 0 = LSB.

## Operation
- Internally, A = {A3,A2,A1,A0}, B = {B3..B0}, CTRL = {CTRL1,CTRL0}, C = {C3..C0}.
- Operation encoding:
  - CTRL=0: ADD. C = (A + B) mod 16; carry-out is discarded.
  - CTRL=1: SUB. C = (A - B) mod 16, in two's complement; borrow is discarded.
  - CTRL=2: AND. C = A & B, bitwise.
  - CTRL=3: OR. C = A | B, bitwise.
- All arithmetic is unsigned 4-bit with wrap-around. No flags, overflow or carry outputs are provided.
- The result is computed combinationally from the current A, B and CTRL, then captured in a 4-bit output register. C is driven only from this register.
- Inputs are not registered. Any X on an input propagates to the register at the next edge; no X filtering is done.

## Timing
- Reset: when rst_n goes low, C is forced to 4'b0000 immediately, independent of clk. C stays at 0 for as long as rst_n is low.
- Reset release: the first rising clk edge with rst_n high loads the ALU result.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N appear on C after edge N, and hold until edge N+1.
- Throughput: a new operation every cycle. There is no handshake; the block is always ready.
- Simultaneous changes: if CTRL and the operands change in the same cycle, the register captures the result of the new CTRL applied to the new operands. There is no mixing of old and new values.
- Reset mid-operation: any pending result is lost, and C reads 0 until the first edge after release.
- Between edges, C must not glitch in response to input changes.

## Test plan
- Reset: hold rst_n=0 with A=2, B=3, CTRL=0 and toggle clk -> C=0. Release rst_n -> C=5 after the next edge. Assert rst_n=0 between edges -> C=0 immediately.
- Operation sweep with A=2, B=3, stepping CTRL 0, 1, 2, 3, one value per cycle -> C=5, 15, 2, 3, each appearing one edge after its CTRL is applied.
- Operand change with CTRL=3: A=3, B=2 -> C=3. Then A=7, B=7 -> C=7. Then A=0, B=0 -> C=0.
- Wrap-around: A=15, B=1, CTRL=0 -> C=0. A=0, B=1, CTRL=1 -> C=15. A=7, B=7, CTRL=0 -> C=14.
- Latency check: change the inputs mid-cycle -> C stays at its old value until the next rising edge, then updates to the new result, with no intermediate value.
- Back-to-back: change CTRL and the operands together every cycle through a random sequence -> C matches the reference model delayed by exactly one cycle.

Source files
------------

// File: rtl/alu_example_unit.sv
// alu_example_unit: 4-bit two-operand ALU (ADD/SUB/AND/OR) with a registered result.
// The operand, select and result bits are individual scalar pins so that each bit
// can be back-annotated on its own. All arithmetic is unsigned and wraps modulo 16.
module alu_example_unit (
  input  logic clk,
  input  logic rst_n,
`ifdef USE_POWER_PINS
  inout  wire  vccd1,
  inout  wire  vssd1,
`endif
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic CTRL0,
  input  logic CTRL1,
  output logic C0,
  output logic C1,
  output logic C2,
  output logic C3
);

  // Operation select encodings.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] ctrl;
  logic [3:0] result_next;
  logic [3:0] c_reg;

  // Gather the scalar pins into vectors; bit 0 is the LSB throughout.
  assign a    = {A3, A2, A1, A0};
  assign b    = {B3, B2, B1, B0};
  assign ctrl = {CTRL1, CTRL0};

  // Combinational ALU; carry and borrow fall off the top of the 4-bit result.
  always_comb begin
    result_next = 4'd0;
    case (ctrl)
      OP_ADD:  result_next = a + b;
      OP_SUB:  result_next = a - b;
      OP_AND:  result_next = a & b;
      OP_OR:   result_next = a | b;
      default: result_next = 4'bxxxx;
    endcase
  end

  // Output register: cleared the moment rst_n drops, otherwise loads the ALU result
  // every rising edge. C comes only from here, so it cannot glitch between edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_reg <= 4'd0;
    end else begin
      c_reg <= result_next;
    end
  end

  // Fan the registered result back out to the scalar pins.
  assign C0 = c_reg[0];
  assign C1 = c_reg[1];
  assign C2 = c_reg[2];
  assign C3 = c_reg[3];

endmodule

// File: tb/tb_alu_example_unit.sv
// Directed plus random bench for alu_example_unit. Expected results are pushed to a
// queue when stimulus is applied and popped when the registered output is sampled.
module tb_alu_example_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] ctrl;
  logic [3:0] c;

`ifdef USE_POWER_PINS
  wire vccd1;
  wire vssd1;
  assign vccd1 = 1'b1;
  assign vssd1 = 1'b0;
`endif

  int compared;
  int mismatched;
  logic [3:0] exp_q[$];

  alu_example_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef USE_POWER_PINS
    .vccd1 (vccd1),
    .vssd1 (vssd1),
`endif
    .A0    (a[0]),
    .A1    (a[1]),
    .A2    (a[2]),
    .A3    (a[3]),
    .B0    (b[0]),
    .B1    (b[1]),
    .B2    (b[2]),
    .B3    (b[3]),
    .CTRL0 (ctrl[0]),
    .CTRL1 (ctrl[1]),
    .C0    (c[0]),
    .C1    (c[1]),
    .C2    (c[2]),
    .C3    (c[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the ALU, computed with wide integers and reduced mod 16.
  function automatic logic [3:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                       input logic [1:0] mc);
    int ia;
    int ib;
    int r;
    ia = int'(ma);
    ib = int'(mb);
    r  = 0;
    case (mc)
      2'd0: r = (ia + ib) % 16;
      2'd1: r = (ia - ib + 16) % 16;
      2'd2: r = int'(ma & mb);
      default: r = int'(ma | mb);
    endcase
    return r[3:0];
  endfunction

  task automatic check_const(input string tag, input logic [3:0] expected);
    compared++;
    $display("check %-14s observed=%0d expected=%0d", tag, c, expected);
    assert (c === expected) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, c, expected);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [3:0] expected;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL %s: observed=%0d expected=<scoreboard empty>", tag, c);
    end else begin
      expected = exp_q.pop_front();
      check_const(tag, expected);
    end
  endtask

  // Apply one operation between edges, then check it one rising edge later.
  task automatic step(input string tag, input logic [3:0] sa, input logic [3:0] sb,
                      input logic [1:0] sc);
    @(negedge clk);
    a = sa;
    b = sb;
    ctrl = sc;
    exp_q.push_back(model(sa, sb, sc));
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held with live inputs: output stays at zero across clock edges.
    rst_n = 1'b0;
    a = 4'd2;
    b = 4'd3;
    ctrl = 2'd0;
    repeat (3) @(negedge clk);
    check_const("reset_hold", 4'd0);
    @(posedge clk);
    #1;
    check_const("reset_edge", 4'd0);

    // Release: the first edge loads 2+3.
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(model(a, b, ctrl));
    @(posedge clk);
    #1;
    check_pop("reset_release");

    // Asynchronous assertion between edges clears C at once.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_const("async_reset", 4'd0);
    @(posedge clk);
    #1;
    check_const("reset_mid", 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_const("post_release", 4'd0);
    @(posedge clk);
    #1;
    check_const("first_after", 4'd5);

    // Operation sweep with A=2, B=3.
    step("sweep_add", 4'd2, 4'd3, 2'd0);
    step("sweep_sub", 4'd2, 4'd3, 2'd1);
    step("sweep_and", 4'd2, 4'd3, 2'd2);
    step("sweep_or",  4'd2, 4'd3, 2'd3);

    // Operand changes under OR.
    step("or_3_2", 4'd3, 4'd2, 2'd3);
    step("or_7_7", 4'd7, 4'd7, 2'd3);
    step("or_0_0", 4'd0, 4'd0, 2'd3);

    // Wrap-around cases.
    step("wrap_add", 4'd15, 4'd1, 2'd0);
    step("wrap_sub", 4'd0,  4'd1, 2'd1);
    step("add_7_7",  4'd7,  4'd7, 2'd0);

    // Latency: a mid-cycle input change must not reach C before the next edge.
    step("lat_base", 4'd5, 4'd6, 2'd2);
    #2;
    a = 4'd9;
    b = 4'd3;
    ctrl = 2'd0;
    exp_q.push_back(model(a, b, ctrl));
    #1;
    check_const("lat_hold", 4'd4);
    @(negedge clk);
    check_const("lat_hold_neg", 4'd4);
    @(posedge clk);
    #1;
    check_pop("lat_update");

    // Back-to-back random operations, every input changing each cycle.
    for (int i = 0; i < 40; i++) begin
      step("random", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           2'($urandom_range(0, 3)));
    end

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_drain: observed=%0d left expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
